// File: rtl/spi_midi_host.sv
// SPI mode-0 host for the 24-bit MIDI link: writes tx words, reads status words on read_needed.
// Latency: a transfer occupies 50*HALF_PERIOD cycles with csn low, then GAP_CYCLES with csn high.
// Backpressure: tx_ready is high only in IDLE; read_needed is only looked at in IDLE.
module spi_midi_host #(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_write_en,
    input  logic        read_needed,
    input  logic [23:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [23:0] rx_data,
    output logic        rx_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] HALF_M1 = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_M1  = 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] tx_shift_q, tx_shift_d;
    logic [23:0] rx_shift_q, rx_shift_d;
    logic [23:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        wen_q, wen_d;
    logic        miso_q, miso_d;
    logic        phase_done;
    logic        xfer_active;

    assign phase_done  = (cnt_q == 8'd0);
    assign xfer_active = (state_q == S_SETUP) || (state_q == S_LOW) ||
                         (state_q == S_HIGH)  || (state_q == S_HOLD);

    // Pins decode straight from the registered state; mosi is forced low outside the frame.
    assign spi_csn      = ~xfer_active;
    assign spi_clk      = (state_q == S_HIGH);
    assign spi_mosi     = xfer_active & tx_shift_q[0];
    assign spi_write_en = wen_q;
    assign tx_ready     = (state_q == S_IDLE) & ~reset;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;

    // Next-state logic: phase counter runs down to zero, then the FSM advances one phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        wen_d      = wen_q;
        miso_d     = spi_miso;
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    wen_d      = 1'b1;
                    bit_d      = 5'd0;
                    cnt_d      = HALF_M1;
                    state_d    = S_SETUP;
                end else if (read_needed) begin
                    tx_shift_d = 24'd0;
                    wen_d      = 1'b0;
                    bit_d      = 5'd0;
                    cnt_d      = HALF_M1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = phase_done ? HALF_M1 : cnt_q - 8'd1;
                if (phase_done) state_d = S_LOW;
            end
            S_LOW: begin
                cnt_d = phase_done ? HALF_M1 : cnt_q - 8'd1;
                if (phase_done) begin
                    // miso_q holds the value seen on the final LOW cycle
                    rx_shift_d = {miso_q, rx_shift_q[23:1]};
                    state_d    = S_HIGH;
                end
            end
            S_HIGH: begin
                cnt_d = phase_done ? HALF_M1 : cnt_q - 8'd1;
                if (phase_done) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (bit_q == 5'd23) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        state_d = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = phase_done ? GAP_M1 : cnt_q - 8'd1;
                if (phase_done) begin
                    state_d = S_GAP;
                    if (!wen_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = phase_done ? 8'd0 : cnt_q - 8'd1;
                if (phase_done) begin
                    wen_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 5'd0;
            tx_shift_q <= 24'd0;
            rx_shift_q <= 24'd0;
            rx_data_q  <= 24'd0;
            rx_valid_q <= 1'b0;
            wen_q      <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            wen_q      <= wen_d;
            miso_q     <= miso_d;
        end
    end

endmodule

// File: tb/tb_spi_midi_host.sv
// Bench for spi_midi_host: a peripheral model records each frame, tasks compare against the word-level model.
// Two instances: default timing (HALF=4, GAP=8) and a fast one (HALF=2) with miso looped to mosi.
// Inputs are driven on the falling clock edge; outputs are observed on the falling edge.
module tb_spi_midi_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csn, spi_sclk, spi_mosi, spi_write_en, tx_ready, rx_valid;
    logic        spi_miso = 1'b0;
    logic        read_needed = 1'b0;
    logic        tx_valid = 1'b0;
    logic [23:0] tx_data = 24'd0;
    logic [23:0] rx_data;

    logic        csn2, sclk2, mosi2, wen2, tx_ready2, rx_valid2, miso2;
    logic        read_needed2 = 1'b0;
    logic        tx_valid2 = 1'b0;
    logic [23:0] tx_data2 = 24'd0;
    logic [23:0] rx_data2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_midi_host #(.HALF_PERIOD(4), .GAP_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_clk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_write_en(spi_write_en), .read_needed(read_needed),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    assign miso2 = mosi2;

    spi_midi_host #(.HALF_PERIOD(2), .GAP_CYCLES(8)) u_dut2 (
        .clk(clk), .reset(reset), .spi_csn(csn2), .spi_clk(sclk2), .spi_mosi(mosi2),
        .spi_miso(miso2), .spi_write_en(wen2), .read_needed(read_needed2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .rx_data(rx_data2), .rx_valid(rx_valid2)
    );

    // ---------------- peripheral model / frame recorder for u_dut ----------------
    typedef struct {
        logic [23:0] mosi;
        int          low_len;
        int          gap;
        logic        wen_rise;
        logic        wen_ok;
        logic        rxv;
        logic        mosi_seen;
    } frame_t;

    frame_t      frames[$];
    frame_t      cur;
    logic [23:0] per_word = 24'd0;
    logic [23:0] last_rx = 24'd0;
    logic        prev_csn = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        wen_start = 1'b0;
    int          bit_idx = 0;
    int          high_len = 0;
    int          rx_pulses = 0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_pulses = rx_pulses + 1;
            last_rx   = rx_data;
        end
        if (spi_csn === 1'b0) begin
            if (prev_csn) begin
                cur.gap       = high_len;
                cur.low_len   = 0;
                cur.mosi      = 24'd0;
                cur.wen_ok    = 1'b1;
                cur.mosi_seen = 1'b0;
                wen_start     = spi_write_en;
                bit_idx       = 0;
                spi_miso      = per_word[0];
            end
            cur.low_len = cur.low_len + 1;
            if (spi_write_en !== wen_start) cur.wen_ok = 1'b0;
            if (spi_mosi === 1'b1) cur.mosi_seen = 1'b1;
            if (spi_sclk && !prev_sclk && bit_idx < 24) begin
                cur.mosi[bit_idx] = spi_mosi;
                bit_idx = bit_idx + 1;
            end
            if (!spi_sclk && prev_sclk && bit_idx < 24) spi_miso = per_word[bit_idx];
        end else begin
            if (!prev_csn) begin
                cur.wen_rise = spi_write_en;
                cur.rxv      = rx_valid;
                frames.push_back(cur);
                high_len = 1;
                spi_miso = 1'b0;
            end else begin
                high_len = high_len + 1;
            end
        end
        prev_csn  = spi_csn;
        prev_sclk = spi_sclk;
    end

    // ---------------- recorder for the fast instance ----------------
    logic [23:0] mosi2_word = 24'd0;
    logic        pc2 = 1'b1;
    logic        ps2 = 1'b0;
    int          cyc = 0;
    int          low2 = 0;
    int          rise2 = 0;
    int          last_rise2 = 0;
    int          bad_per2 = 0;
    int          f2_done = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (csn2 === 1'b0) begin
            if (pc2) begin
                low2 = 0; rise2 = 0; bad_per2 = 0; mosi2_word = 24'd0;
            end
            low2 = low2 + 1;
            if (sclk2 && !ps2) begin
                if (rise2 > 0 && (cyc - last_rise2) != 4) bad_per2 = bad_per2 + 1;
                last_rise2 = cyc;
                if (rise2 < 24) mosi2_word[rise2] = miso2;
                rise2 = rise2 + 1;
            end
        end else if (!pc2) begin
            f2_done = f2_done + 1;
        end
        pc2 = csn2;
        ps2 = sclk2;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (frames.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_csn_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (spi_csn === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (spi_csn !== 1'b1) $display("FAIL rst_csn got=%b exp=1", spi_csn); else n_pass++;
        n_chk++; if (spi_sclk !== 1'b0) $display("FAIL rst_sclk got=%b exp=0", spi_sclk); else n_pass++;
        n_chk++; if (spi_mosi !== 1'b0) $display("FAIL rst_mosi got=%b exp=0", spi_mosi); else n_pass++;
        n_chk++; if (spi_write_en !== 1'b0) $display("FAIL rst_wen got=%b exp=0", spi_write_en); else n_pass++;
        n_chk++; if (rx_data !== 24'd0) $display("FAIL rst_rx_data got=%h exp=000000", rx_data); else n_pass++;
        n_chk++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); else n_pass++;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (tx_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", tx_ready); else n_pass++;
    endtask

    task automatic test_write(input logic [23:0] d);
        bit ok;
        int base, pulses0;
        wait_ready(ok);
        n_chk++; if (!ok) begin $display("FAIL wr_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        base    = frames.size();
        pulses0 = rx_pulses;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n_chk++; if (tx_ready !== 1'b0) $display("FAIL wr_ready_drop got=%b exp=0", tx_ready); else n_pass++;
        wait_frames(base + 1, ok);
        n_chk++; if (!ok) begin $display("FAIL wr_frame_timeout got=none exp=frame"); return; end else n_pass++;
        repeat (4) @(negedge clk);
        n_chk++; if (frames[base].mosi !== d) $display("FAIL wr_mosi got=%h exp=%h", frames[base].mosi, d); else n_pass++;
        n_chk++; if (frames[base].low_len != 200) $display("FAIL wr_csn_low got=%0d exp=200", frames[base].low_len); else n_pass++;
        n_chk++; if (frames[base].wen_rise !== 1'b1 || frames[base].wen_ok !== 1'b1)
            $display("FAIL wr_wen got=%b/%b exp=1/1", frames[base].wen_rise, frames[base].wen_ok); else n_pass++;
        n_chk++; if (rx_pulses != pulses0) $display("FAIL wr_no_rxv got=%0d exp=%0d", rx_pulses, pulses0); else n_pass++;
    endtask

    task automatic test_read(input logic [23:0] w);
        bit ok;
        int base, pulses0;
        wait_ready(ok);
        n_chk++; if (!ok) begin $display("FAIL rd_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        base     = frames.size();
        pulses0  = rx_pulses;
        per_word = w;
        read_needed = 1'b1;
        wait_csn_low(ok);
        read_needed = 1'b0;
        wait_frames(base + 1, ok);
        n_chk++; if (!ok) begin $display("FAIL rd_frame_timeout got=none exp=frame"); return; end else n_pass++;
        repeat (4) @(negedge clk);
        n_chk++; if (frames[base].wen_rise !== 1'b0 || frames[base].wen_ok !== 1'b1)
            $display("FAIL rd_wen got=%b/%b exp=0/1", frames[base].wen_rise, frames[base].wen_ok); else n_pass++;
        n_chk++; if (frames[base].mosi_seen !== 1'b0) $display("FAIL rd_mosi_zero got=1 exp=0"); else n_pass++;
        n_chk++; if (frames[base].low_len != 200) $display("FAIL rd_csn_low got=%0d exp=200", frames[base].low_len); else n_pass++;
        n_chk++; if (frames[base].rxv !== 1'b1) $display("FAIL rd_rxv_at_rise got=%b exp=1", frames[base].rxv); else n_pass++;
        n_chk++; if (rx_pulses != pulses0 + 1) $display("FAIL rd_pulse_count got=%0d exp=%0d", rx_pulses - pulses0, 1); else n_pass++;
        n_chk++; if (rx_data !== w) $display("FAIL rd_rx_data got=%h exp=%h", rx_data, w); else n_pass++;
    endtask

    task automatic test_priority(input logic [23:0] a, input logic [23:0] w);
        bit ok;
        int base, pulses0;
        wait_ready(ok);
        n_chk++; if (!ok) begin $display("FAIL pri_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        base     = frames.size();
        pulses0  = rx_pulses;
        per_word = w;
        tx_data  = a;
        tx_valid = 1'b1;
        read_needed = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_frames(base + 1, ok);
        wait_csn_low(ok);
        read_needed = 1'b0;
        wait_frames(base + 2, ok);
        n_chk++; if (!ok) begin $display("FAIL pri_frame_timeout got=missing exp=2 frames"); return; end else n_pass++;
        repeat (4) @(negedge clk);
        n_chk++; if (frames[base].wen_rise !== 1'b1 || frames[base].mosi !== a)
            $display("FAIL pri_write_first got=%b/%h exp=1/%h", frames[base].wen_rise, frames[base].mosi, a); else n_pass++;
        n_chk++; if (frames[base + 1].wen_rise !== 1'b0) $display("FAIL pri_read_second got=%b exp=0", frames[base + 1].wen_rise); else n_pass++;
        n_chk++; if (frames[base + 1].gap != 9) $display("FAIL pri_gap got=%0d exp=9", frames[base + 1].gap); else n_pass++;
        n_chk++; if (rx_pulses != pulses0 + 1) $display("FAIL pri_pulses got=%0d exp=1", rx_pulses - pulses0); else n_pass++;
        n_chk++; if (last_rx !== w) $display("FAIL pri_rx_data got=%h exp=%h", last_rx, w); else n_pass++;
    endtask

    task automatic test_reset_mid(input logic [23:0] w);
        bit ok;
        int pulses0;
        wait_ready(ok);
        n_chk++; if (!ok) begin $display("FAIL rm_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        pulses0  = rx_pulses;
        per_word = w;
        read_needed = 1'b1;
        wait_csn_low(ok);
        read_needed = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bit_idx == 11 && spi_sclk === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_chk++; if (!ok) begin $display("FAIL rm_bit10_timeout got=none exp=bit10 high"); return; end else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (spi_csn !== 1'b1 || spi_sclk !== 1'b0)
            $display("FAIL rm_pins got=%b/%b exp=1/0", spi_csn, spi_sclk); else n_pass++;
        n_chk++; if (rx_valid !== 1'b0 || rx_data !== 24'd0)
            $display("FAIL rm_rx got=%b/%h exp=0/000000", rx_valid, rx_data); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++; if (tx_ready !== 1'b1) $display("FAIL rm_ready_after got=%b exp=1", tx_ready); else n_pass++;
        repeat (250) @(negedge clk);
        n_chk++; if (rx_pulses != pulses0) $display("FAIL rm_no_rxv got=%0d exp=0", rx_pulses - pulses0); else n_pass++;
        n_chk++; if (spi_csn !== 1'b1) $display("FAIL rm_stays_idle got=%b exp=1", spi_csn); else n_pass++;
    endtask

    task automatic test_back_to_back(input logic [23:0] a, input logic [23:0] b);
        bit ok;
        int base;
        wait_ready(ok);
        n_chk++; if (!ok) begin $display("FAIL b2b_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        base     = frames.size();
        tx_data  = a;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = b;
        wait_frames(base + 1, ok);
        wait_csn_low(ok);
        tx_valid = 1'b0;
        wait_frames(base + 2, ok);
        n_chk++; if (!ok) begin $display("FAIL b2b_frame_timeout got=missing exp=2 frames"); return; end else n_pass++;
        n_chk++; if (frames[base].mosi !== a) $display("FAIL b2b_word_a got=%h exp=%h", frames[base].mosi, a); else n_pass++;
        n_chk++; if (frames[base + 1].mosi !== b) $display("FAIL b2b_word_b got=%h exp=%h", frames[base + 1].mosi, b); else n_pass++;
        n_chk++; if (frames[base + 1].gap != 9) $display("FAIL b2b_gap got=%0d exp=9", frames[base + 1].gap); else n_pass++;
        n_chk++; if (frames[base + 1].low_len != 200) $display("FAIL b2b_csn_low got=%0d exp=200", frames[base + 1].low_len); else n_pass++;
    endtask

    task automatic test_half2(input logic [23:0] d);
        bit ok;
        int done0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready2 === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) begin $display("FAIL h2_idle_timeout got=busy exp=ready"); return; end else n_pass++;
        done0    = f2_done;
        tx_data2 = d;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (f2_done > done0) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) begin $display("FAIL h2_frame_timeout got=none exp=frame"); return; end else n_pass++;
        n_chk++; if (low2 != 100) $display("FAIL h2_csn_low got=%0d exp=100", low2); else n_pass++;
        n_chk++; if (rise2 != 24 || bad_per2 != 0) $display("FAIL h2_sclk got=%0d rises/%0d bad exp=24/0", rise2, bad_per2); else n_pass++;
        n_chk++; if (mosi2_word !== d) $display("FAIL h2_loopback got=%h exp=%h", mosi2_word, d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write(24'h7F3C90);
        for (int i = 0; i < 2; i++) test_write(24'($urandom));
        test_read(24'h803C90);
        test_read(24'($urandom));
        test_priority(24'($urandom), 24'($urandom));
        test_reset_mid(24'($urandom));
        test_back_to_back(24'($urandom), 24'($urandom));
        test_half2(24'($urandom));
        test_half2(24'hA5F00F);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
